occupancy_updater: RTL and testbench

OCCUPANCY_UPDATER -- requirements
Module: occupancy_updater

---
 rtl/occupancy_updater.sv | 192 +++++++++++++++++++
 tb/tb_occupancy_updater.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_updater.sv
// Occupancy grid log-odds updater.
// Holds a 32x32 map of signed 8-bit log-odds values. Occupied hits add
// LO_OCC and free passes subtract LO_FREE, saturating at +/-LO_MAX. A
// one-stage pipeline reads the old value on the accept edge and writes the
// new one on the following edge. A last-written-value register bridges
// back-to-back hits on the same cell. The map clears itself after reset and
// on request, one cell per cycle.
module occupancy_updater #(
   parameter int GRID_W  = 5,
   parameter int LO_OCC  = 9,
   parameter int LO_FREE = 3,
   parameter int LO_MAX  = 127
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_enable,
   input  logic                     cell_is_free,
   input  logic [GRID_W-1:0]        cell_x,
   input  logic [GRID_W-1:0]        cell_y,
   input  logic                     clear_req,
   input  logic [GRID_W-1:0]        rd_x,
   input  logic [GRID_W-1:0]        rd_y,
   output logic signed [7:0]        rd_data,
   output logic                     occupancy_busy,
   output logic                     dropped,
   output logic [15:0]              update_count
);

   localparam int ADDR_W = 2 * GRID_W;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] IDLE  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic signed [8:0] OCC_INC  = 9'(LO_OCC);
   localparam logic signed [8:0] FREE_DEC = 9'(LO_FREE);
   localparam logic signed [8:0] SAT_HI   = 9'(LO_MAX);
   localparam logic signed [8:0] SAT_LO   = 9'(-LO_MAX);

   logic [1:0]              state;
   logic [ADDR_W-1:0]       clr_cnt;
   logic signed [7:0]       mem [DEPTH];

   logic                    accept;
   logic [ADDR_W-1:0]       req_addr;

   logic                    s1_valid;
   logic                    s1_free;
   logic [ADDR_W-1:0]       s1_addr;
   logic signed [7:0]       s1_mem_old;
   logic signed [7:0]       s1_old;
   logic signed [8:0]       s1_ext;
   logic signed [8:0]       s1_sum;
   logic signed [7:0]       s1_new;

   logic                    last_valid;
   logic [ADDR_W-1:0]       last_addr;
   logic signed [7:0]       last_data;

   assign req_addr       = {cell_y, cell_x};
   assign accept         = (state == IDLE) && write_enable;
   assign occupancy_busy = (state != IDLE) || s1_valid;

   // Pick the freshest old value and apply the saturating log-odds step.
   // The memory read for this cell was issued on the same edge that wrote
   // the previous update, so a hit on that same cell must use the
   // last-written register instead of the stale memory word.
   always_comb begin
      s1_old = s1_mem_old;
      if (last_valid && (last_addr == s1_addr)) begin
         s1_old = last_data;
      end
      s1_ext = 9'(s1_old);
      s1_sum = s1_ext;
      if (s1_free) begin
         s1_sum = s1_ext - FREE_DEC;
         if (s1_sum < SAT_LO) begin
            s1_sum = SAT_LO;
         end
      end else begin
         s1_sum = s1_ext + OCC_INC;
         if (s1_sum > SAT_HI) begin
            s1_sum = SAT_HI;
         end
      end
      s1_new = s1_sum[7:0];
   end

   // Single memory write port: clear sweep or pipeline commit. The two never
   // overlap because clearing only starts once the pipeline stage is empty.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
         end else if (s1_valid) begin
            mem[s1_addr] <= s1_new;
         end
      end
   end

   // Pipeline read of the old cell value, issued on the accept edge.
   always_ff @(posedge clock) begin
      s1_mem_old <= mem[req_addr];
   end

   // External read port returns committed contents one cycle later.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[{rd_y, rd_x}];
      end
   end

   // Pipeline stage register and the record of the most recent commit.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_free    <= 1'b0;
         s1_addr    <= '0;
         last_valid <= 1'b0;
         last_addr  <= '0;
         last_data  <= '0;
      end else begin
         s1_valid   <= accept;
         last_valid <= s1_valid;
         if (accept) begin
            s1_free <= cell_is_free;
            s1_addr <= req_addr;
         end
         if (s1_valid) begin
            last_addr <= s1_addr;
            last_data <= s1_new;
         end
      end
   end

   // Commit counter and sticky flag for requests arriving while not idle.
   always_ff @(posedge clock) begin
      if (reset) begin
         update_count <= '0;
         dropped      <= 1'b0;
      end else begin
         if (s1_valid) begin
            update_count <= update_count + 16'd1;
         end
         if (write_enable && (state != IDLE)) begin
            dropped <= 1'b1;
         end
      end
   end

   // Control FSM. A clear request that arrives together with an update, or
   // while one is in flight, passes through DRAIN so the pending commit lands
   // before the sweep. Nothing is accepted in DRAIN, so the stage is always
   // empty after one DRAIN cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == '1) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (clear_req) begin
                  clr_cnt <= '0;
                  if (s1_valid || write_enable) begin
                     state <= DRAIN;
                  end else begin
                     state <= CLEAR;
                  end
               end
            end
            DRAIN: begin
               state   <= CLEAR;
               clr_cnt <= '0;
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_occupancy_updater.sv
// Self-checking bench for occupancy_updater: directed saturation, forwarding,
// drain/clear and reset-restart scenarios, then randomized traffic compared
// against a sequential log-odds model of the map.
module tb_occupancy_updater;

   logic              clock;
   logic              reset;
   logic              write_enable;
   logic              cell_is_free;
   logic [4:0]        cell_x;
   logic [4:0]        cell_y;
   logic              clear_req;
   logic [4:0]        rd_x;
   logic [4:0]        rd_y;
   logic signed [7:0] rd_data;
   logic              occupancy_busy;
   logic              dropped;
   logic [15:0]       update_count;

   int checks;
   int errors;
   int n;
   int value;
   int model_mem [1024];
   int model_count;

   occupancy_updater dut (
      .clock          (clock),
      .reset          (reset),
      .write_enable   (write_enable),
      .cell_is_free   (cell_is_free),
      .cell_x         (cell_x),
      .cell_y         (cell_y),
      .clear_req      (clear_req),
      .rd_x           (rd_x),
      .rd_y           (rd_y),
      .rd_data        (rd_data),
      .occupancy_busy (occupancy_busy),
      .dropped        (dropped),
      .update_count   (update_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expectation and count it.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one cycle's worth of request inputs.
   task automatic applyStimulus(input logic we, input logic free, input int x, input int y,
                                input logic clr);
      write_enable = we;
      cell_is_free = free;
      cell_x       = x[4:0];
      cell_y       = y[4:0];
      clear_req    = clr;
   endtask

   // Present a read address and return the value one cycle later.
   task automatic readCell(input int x, input int y, output int v);
      rd_x = x[4:0];
      rd_y = y[4:0];
      tick();
      v = rd_data;
   endtask

   // Count samples with busy high, bounded so a stuck design still finishes.
   task automatic countBusy(output int cycles);
      cycles = 0;
      while (occupancy_busy && cycles < 2000) begin
         cycles++;
         tick();
      end
   endtask

   // Reference log-odds step, straight from the saturation rules.
   function automatic int stepLogOdds(input int old, input logic free);
      int v;
      if (free) begin
         v = old - 3;
         if (v < -127) v = -127;
      end else begin
         v = old + 9;
         if (v > 127) v = 127;
      end
      return v;
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      rd_x   = '0;
      rd_y   = '0;
      applyStimulus(0, 0, 0, 0, 0);

      // Reset state
      tick();
      tick();
      checkOutput("reset_rd_data", rd_data, 0);
      checkOutput("reset_busy", occupancy_busy, 1);
      checkOutput("reset_dropped", dropped, 0);
      checkOutput("reset_count", update_count, 0);

      // Initial clear sweep after reset release
      reset = 1'b0;
      countBusy(n);
      checkOutput("init_busy_cycles", n, 1024);
      readCell(31, 31, value);
      checkOutput("init_read_31_31", value, 0);

      // Twenty occupied hits on one cell saturate at +127
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 0, 3, 4, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      readCell(3, 4, value);
      checkOutput("occ_saturate", value, 127);
      checkOutput("occ_count", update_count, 20);

      // Fifty free passes reach -127 and never show -128
      rd_x = 5'd0;
      rd_y = 5'd0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         tick();
         if (i % 10 == 9) checkOutput("free_no_neg128", (rd_data == -8'sd128), 0);
      end
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      readCell(0, 0, value);
      checkOutput("free_saturate", value, -127);
      checkOutput("free_count", update_count, 70);

      // Alternating hits on one cell need forwarding: 9, 6, 15, 12
      applyStimulus(1, 0, 7, 7, 0);
      tick();
      applyStimulus(1, 1, 7, 7, 0);
      tick();
      applyStimulus(1, 0, 7, 7, 0);
      tick();
      applyStimulus(1, 1, 7, 7, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      readCell(7, 7, value);
      checkOutput("forward_alt", value, 12);
      checkOutput("forward_count", update_count, 74);
      checkOutput("dropped_before_clear", dropped, 0);

      // Clear request alongside an update with the stage busy
      applyStimulus(1, 0, 10, 10, 0);
      tick();
      applyStimulus(1, 0, 10, 10, 1);
      tick();
      checkOutput("drain_busy", occupancy_busy, 1);
      n = 0;
      while (occupancy_busy && n < 2000) begin
         n++;
         applyStimulus((n == 100), 0, 1, 1, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drain_clear_cycles", n, 1025);
      checkOutput("drain_dropped", dropped, 1);
      checkOutput("drain_count", update_count, 76);
      readCell(10, 10, value);
      checkOutput("clear_10_10", value, 0);
      readCell(3, 4, value);
      checkOutput("clear_3_4", value, 0);
      readCell(0, 0, value);
      checkOutput("clear_0_0", value, 0);
      readCell(1, 1, value);
      checkOutput("clear_dropped_cell", value, 0);

      // Reset with an update in flight, then reset again mid-clear
      applyStimulus(1, 0, 20, 20, 0);
      tick();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      checkOutput("rst_flight_busy", occupancy_busy, 1);
      checkOutput("rst_flight_count", update_count, 0);
      checkOutput("rst_flight_dropped", dropped, 0);
      for (int i = 0; i < 500; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      countBusy(n);
      checkOutput("rst_mid_clear_cycles", n, 1024);
      checkOutput("rst_mid_clear_count", update_count, 0);
      readCell(20, 20, value);
      checkOutput("rst_abandoned_cell", value, 0);

      // Randomized traffic over a small patch against the reference map
      for (int i = 0; i < 1024; i++) model_mem[i] = 0;
      model_count = 0;
      for (int i = 0; i < 400; i++) begin
         logic we;
         logic fr;
         int   x;
         int   y;
         we = ($urandom_range(0, 3) != 0);
         fr = ($urandom_range(0, 3) != 0);
         x  = $urandom_range(0, 3);
         y  = $urandom_range(0, 3);
         applyStimulus(we, fr, x, y, 0);
         if (we) begin
            model_mem[y * 32 + x] = stepLogOdds(model_mem[y * 32 + x], fr);
            model_count++;
         end
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      tick();
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            readCell(x, y, value);
            checkOutput($sformatf("rand_cell_%0d_%0d", x, y), value, model_mem[y * 32 + x]);
         end
      end
      readCell(31, 31, value);
      checkOutput("rand_untouched", value, 0);
      checkOutput("rand_count", update_count, model_count);
      checkOutput("rand_dropped", dropped, 0);
      checkOutput("rand_idle", occupancy_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
